// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states
// and the iteration counter sizing helper.
package mdu_pkg;

   typedef enum logic [1:0] {
      MDU_MULT  = 2'b00,
      MDU_MULTU = 2'b01,
      MDU_DIV   = 2'b10,
      MDU_DIVU  = 2'b11
   } mdu_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      MUL  = 2'b01,
      DIV  = 2'b10,
      DONE = 2'b11
   } mdu_state_e;

   function automatic int cnt_width(input int width);
      return $clog2(width) + 1;
   endfunction

endpackage

// File: rtl/mdu_divstep.sv
// One combinational restoring-division step: shift in the next dividend bit
// and subtract the divisor when it fits.
module mdu_divstep #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic [WIDTH-1:0] quo_i,
   input  logic [WIDTH-1:0] div_i,
   output logic [WIDTH-1:0] rem_o,
   output logic [WIDTH-1:0] quo_o
);

   logic [WIDTH:0] rem_sh;
   logic [WIDTH:0] diff;

   always_comb begin
      rem_sh = {rem_i, quo_i[WIDTH-1]};
      diff   = rem_sh - {1'b0, div_i};
      // The remainder stays below the divisor, so bit WIDTH of diff is a pure borrow.
      if (!diff[WIDTH]) begin
         rem_o = diff[WIDTH-1:0];
         quo_o = {quo_i[WIDTH-2:0], 1'b1};
      end else begin
         rem_o = rem_sh[WIDTH-1:0];
         quo_o = {quo_i[WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit producing HI/LO with a start/ready/ack
// handshake; results are held until acknowledged, cancel_i aborts any operation.
module muldiv_unit
   import mdu_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter bit FAST_MUL = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [1:0]       op_i,
   input  logic [WIDTH-1:0] src_a_i,
   input  logic [WIDTH-1:0] src_b_i,
   input  logic             cancel_i,
   input  logic             ack_i,
   output logic             busy_o,
   output logic             ready_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o,
   output logic             div_by_zero_o
);

   localparam int CW = cnt_width(WIDTH);

   mdu_state_e       state_q, state_d;
   mdu_op_e          op_q, op_d, op_in;
   logic             sign_a_q, sign_a_d, sign_b_q, sign_b_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] opnd_q, opnd_d;
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
   logic             dbz_q, dbz_d;

   logic             in_signed, in_sa, in_sb, accept;
   logic [WIDTH-1:0] abs_a, abs_b;
   logic [2*WIDTH-1:0] ext_a, ext_b, fast_prod, prod_neg;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH-1:0] step_hi, step_lo, div_rem, div_quo;

   // hi_q holds the partial remainder and lo_q the dividend/quotient while dividing.
   mdu_divstep #(.WIDTH(WIDTH)) u_divstep (
      .rem_i (hi_q),
      .quo_i (lo_q),
      .div_i (opnd_q),
      .rem_o (div_rem),
      .quo_o (div_quo)
   );

   always_comb begin
      op_in     = mdu_op_e'(op_i);
      in_signed = (op_in == MDU_MULT) || (op_in == MDU_DIV);
      in_sa     = in_signed & src_a_i[WIDTH-1];
      in_sb     = in_signed & src_b_i[WIDTH-1];
      abs_a     = in_sa ? -src_a_i : src_a_i;
      abs_b     = in_sb ? -src_b_i : src_b_i;
      ext_a     = in_signed ? {{WIDTH{src_a_i[WIDTH-1]}}, src_a_i} : {{WIDTH{1'b0}}, src_a_i};
      ext_b     = in_signed ? {{WIDTH{src_b_i[WIDTH-1]}}, src_b_i} : {{WIDTH{1'b0}}, src_b_i};
      fast_prod = ext_a * ext_b;

      // Shift-add step: {hi, lo} shifts right, multiplier bits consumed from lo[0].
      mul_sum  = {1'b0, hi_q} + ({1'b0, opnd_q} & {(WIDTH+1){lo_q[0]}});
      step_hi  = mul_sum[WIDTH:1];
      step_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};
      prod_neg = -{step_hi, step_lo};

      accept = start_i && !cancel_i &&
               ((state_q == IDLE) || ((state_q == DONE) && ack_i));
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      sign_a_d = sign_a_q;
      sign_b_d = sign_b_q;
      cnt_d    = cnt_q;
      opnd_d   = opnd_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      dbz_d    = dbz_q;

      unique case (state_q)
         MUL: begin
            cnt_d = cnt_q - CW'(1);
            hi_d  = step_hi;
            lo_d  = step_lo;
            if (cnt_q <= CW'(1)) begin
               if ((op_q == MDU_MULT) && (sign_a_q ^ sign_b_q)) begin
                  {hi_d, lo_d} = prod_neg;
               end
               state_d = DONE;
            end
         end
         DIV: begin
            cnt_d = cnt_q - CW'(1);
            hi_d  = div_rem;
            lo_d  = div_quo;
            if (cnt_q <= CW'(1)) begin
               if (op_q == MDU_DIV) begin
                  if (sign_a_q ^ sign_b_q) lo_d = -div_quo;
                  if (sign_a_q)            hi_d = -div_rem;
               end
               state_d = DONE;
            end
         end
         DONE: begin
            if (ack_i) begin
               state_d = IDLE;
               dbz_d   = 1'b0;
            end
         end
         default: ;
      endcase

      if (accept) begin
         op_d     = op_in;
         sign_a_d = in_sa;
         sign_b_d = in_sb;
         dbz_d    = 1'b0;
         if (!op_in[1]) begin
            if (FAST_MUL) begin
               {hi_d, lo_d} = fast_prod;
               state_d      = DONE;
            end else begin
               hi_d    = '0;
               lo_d    = abs_b;
               opnd_d  = abs_a;
               cnt_d   = CW'(WIDTH);
               state_d = MUL;
            end
         end else if (src_b_i == '0) begin
            hi_d    = src_a_i;
            lo_d    = '1;
            dbz_d   = 1'b1;
            state_d = DONE;
         end else begin
            hi_d    = '0;
            lo_d    = abs_a;
            opnd_d  = abs_b;
            cnt_d   = CW'(WIDTH);
            state_d = DIV;
         end
      end

      if (cancel_i) begin
         state_d = IDLE;
         dbz_d   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         op_q     <= MDU_MULT;
         sign_a_q <= 1'b0;
         sign_b_q <= 1'b0;
         cnt_q    <= '0;
         opnd_q   <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         dbz_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         sign_a_q <= sign_a_d;
         sign_b_q <= sign_b_d;
         cnt_q    <= cnt_d;
         opnd_q   <= opnd_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         dbz_q    <= dbz_d;
      end
   end

   assign busy_o        = (state_q == MUL) || (state_q == DIV);
   assign ready_o       = (state_q == DONE);
   assign hi_o          = hi_q;
   assign lo_o          = lo_q;
   assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit with a fast-multiply and an iterative-multiply instance.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_i, cancel_i, ack_i;
   logic [1:0]  op_i;
   logic [31:0] src_a_i, src_b_i;

   logic        busy_f, ready_f, dbz_f;
   logic [31:0] hi_f, lo_f;
   logic        busy_s, ready_s, dbz_s;
   logic [31:0] hi_s, lo_s;

   int checks = 0;
   int errors = 0;
   int lat;

   always #5 clk = ~clk;

   muldiv_unit #(.WIDTH(32), .FAST_MUL(1'b1)) dut_f (
      .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
      .src_a_i(src_a_i), .src_b_i(src_b_i), .cancel_i(cancel_i), .ack_i(ack_i),
      .busy_o(busy_f), .ready_o(ready_f), .hi_o(hi_f), .lo_o(lo_f),
      .div_by_zero_o(dbz_f)
   );

   muldiv_unit #(.WIDTH(32), .FAST_MUL(1'b0)) dut_s (
      .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
      .src_a_i(src_a_i), .src_b_i(src_b_i), .cancel_i(cancel_i), .ack_i(ack_i),
      .busy_o(busy_s), .ready_o(ready_s), .hi_o(hi_s), .lo_o(lo_s),
      .div_by_zero_o(dbz_s)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      op_i    = op;
      src_a_i = a;
      src_b_i = b;
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
   endtask

   task automatic ack_result();
      ack_i = 1'b1;
      tick();
      ack_i = 1'b0;
   endtask

   task automatic wait_fast(output int n);
      n = 1;
      while (ready_f !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
   endtask

   task automatic wait_slow(output int n);
      n = 1;
      while (ready_s !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
   endtask

   always @(negedge clk) begin
      if (rst === 1'b0) begin
         checks++;
         assert (!((busy_f && ready_f) || (busy_s && ready_s))) else begin
            errors++;
            $error("FAIL busy_and_ready: observed busy_f=%0b ready_f=%0b busy_s=%0b ready_s=%0b expected not both",
                   busy_f, ready_f, busy_s, ready_s);
         end
      end
   end

   initial begin
      rst = 1'b1; start_i = 1'b0; cancel_i = 1'b0; ack_i = 1'b0;
      op_i = 2'b00; src_a_i = '0; src_b_i = '0;
      tick();
      tick();
      rst = 1'b0;

      check("rst_busy",  32'(busy_f),  32'd0);
      check("rst_ready", 32'(ready_f), 32'd0);
      check("rst_dbz",   32'(dbz_f),   32'd0);
      check("rst_hi",    hi_f,         32'd0);
      check("rst_lo",    lo_f,         32'd0);
      check("rst_hi_s",  hi_s,         32'd0);

      // MULTU max * max on both multiplier implementations
      issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      check("multu_fast_ready", 32'(ready_f), 32'd1);
      check("multu_fast_hi",    hi_f,         32'hFFFF_FFFE);
      check("multu_fast_lo",    lo_f,         32'h0000_0001);
      check("multu_slow_busy",  32'(busy_s),  32'd1);
      wait_slow(lat);
      check("multu_slow_lat",   32'(lat),     32'd33);
      check("multu_slow_hi",    hi_s,         32'hFFFF_FFFE);
      check("multu_slow_lo",    lo_s,         32'h0000_0001);
      check("multu_fast_hold",  lo_f,         32'h0000_0001);
      ack_result();

      // DIV 7 / -2
      issue(2'b10, 32'd7, 32'hFFFF_FFFE);
      wait_fast(lat);
      check("div_lat", 32'(lat),   32'd33);
      check("div_lo",  lo_f,       32'hFFFF_FFFD);
      check("div_hi",  hi_f,       32'h0000_0001);
      check("div_dbz", 32'(dbz_f), 32'd0);
      ack_result();

      // MULT -3 * 5 on both implementations
      issue(2'b00, 32'hFFFF_FFFD, 32'd5);
      check("mult_fast_ready", 32'(ready_f), 32'd1);
      check("mult_fast_hi",    hi_f,         32'hFFFF_FFFF);
      check("mult_fast_lo",    lo_f,         32'hFFFF_FFF1);
      wait_slow(lat);
      check("mult_slow_lat",   32'(lat),     32'd33);
      check("mult_slow_hi",    hi_s,         32'hFFFF_FFFF);
      check("mult_slow_lo",    lo_s,         32'hFFFF_FFF1);
      ack_result();

      // DIV most-negative / -1 wraps
      issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_fast(lat);
      check("ovf_lat", 32'(lat),   32'd33);
      check("ovf_lo",  lo_f,       32'h8000_0000);
      check("ovf_hi",  hi_f,       32'h0000_0000);
      check("ovf_dbz", 32'(dbz_f), 32'd0);
      ack_result();

      // DIVU 5 / 0
      issue(2'b11, 32'd5, 32'd0);
      wait_fast(lat);
      check("dbz_lat", 32'(lat),   32'd1);
      check("dbz_hi",  hi_f,       32'd5);
      check("dbz_lo",  lo_f,       32'hFFFF_FFFF);
      check("dbz_flag", 32'(dbz_f), 32'd1);
      ack_result();
      check("dbz_ack_ready", 32'(ready_f), 32'd0);
      check("dbz_ack_flag",  32'(dbz_f),   32'd0);
      check("dbz_ack_hi",    hi_f,         32'd5);
      check("dbz_ack_lo",    lo_f,         32'hFFFF_FFFF);

      // DIV cancelled in cycle 10, with start_i ignored while busy
      issue(2'b10, 32'd1000, 32'd3);
      op_i = 2'b01; src_a_i = 32'd2; src_b_i = 32'd2;
      start_i = 1'b1;
      for (int i = 0; i < 8; i++) tick();
      check("busy_start_ignored", 32'(busy_f), 32'd1);
      tick();
      start_i  = 1'b0;
      cancel_i = 1'b1;
      tick();
      cancel_i = 1'b0;
      check("cancel_busy",  32'(busy_f),  32'd0);
      check("cancel_ready", 32'(ready_f), 32'd0);
      issue(2'b11, 32'd100, 32'd7);
      wait_fast(lat);
      check("after_cancel_lat", 32'(lat), 32'd33);
      check("after_cancel_lo",  lo_f,     32'd14);
      check("after_cancel_hi",  hi_f,     32'd2);

      // Hold without ack, start ignored; then back-to-back ack+start
      op_i = 2'b01; src_a_i = 32'd9; src_b_i = 32'd9;
      start_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("hold_ready", 32'(ready_f), 32'd1);
         check("hold_lo",    lo_f,         32'd14);
         check("hold_hi",    hi_f,         32'd2);
      end
      src_a_i = 32'd3; src_b_i = 32'd4;
      ack_i = 1'b1;
      tick();
      ack_i = 1'b0; start_i = 1'b0;
      check("b2b_ready", 32'(ready_f), 32'd1);
      check("b2b_busy",  32'(busy_f),  32'd0);
      check("b2b_lo",    lo_f,         32'd12);
      check("b2b_hi",    hi_f,         32'd0);
      ack_result();
      check("b2b_ack_ready", 32'(ready_f), 32'd0);
      check("b2b_ack_lo",    lo_f,         32'd12);

      // Reset in the middle of a divide discards it
      issue(2'b10, 32'd50, 32'd7);
      tick(); tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_busy", 32'(busy_f), 32'd0);
      check("midrst_hi",   hi_f,        32'd0);
      check("midrst_lo",   lo_f,        32'd0);
      for (int i = 0; i < 40; i++) tick();
      check("midrst_no_ready", 32'(ready_f), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
